// File: rtl/fp_check_pkg.sv
// fp_wire -- shared types and constants for the FP result checker.
//   fp_check_entry   : one expected-result record (result, flags, one-hot opcode)
//   FP_CANON_NAN     : canonical quiet NaN produced by fp_unit
//   fp_check_state_e : checker FSM states
//   fp_entry_match() : compare a response against an expected entry
package fp_wire;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic [9:0]  opcode;   // one-hot, bit 9 = fcvt_f2i
  } fp_check_entry;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fp_check_state_e;

  // A canonical NaN from a float-producing op only has to agree on the
  // exponent and quiet bit: the reference model may emit any NaN payload/sign.
  // Integer conversions (opcode bit 9) are always compared bit-exact.
  function automatic logic fp_entry_match(input fp_check_entry exp_e,
                                          input logic [31:0]   res,
                                          input logic [4:0]    flg);
    logic res_ok;
    if (!exp_e.opcode[9] && (res == FP_CANON_NAN)) begin
      res_ok = (res[30:22] == exp_e.result[30:22]);
    end else begin
      res_ok = (res == exp_e.result);
    end
    return res_ok && (flg == exp_e.flags);
  endfunction

endpackage

// File: rtl/fp_check_if.sv
// fp_check_if -- push (expected entry) and response buses of the checker.
//   push_valid/push_result/push_flags/push_opcode : expected entry offer
//   push_ready                                    : checker can accept an entry
//   rsp_valid/rsp_result/rsp_flags                : fp_unit result strobe
// master = stimulus side, slave = fp_check.
interface fp_check_if;
  logic        push_valid;
  logic [31:0] push_result;
  logic [4:0]  push_flags;
  logic [9:0]  push_opcode;
  logic        push_ready;
  logic        rsp_valid;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;

  modport master (
    output push_valid, push_result, push_flags, push_opcode,
    output rsp_valid, rsp_result, rsp_flags,
    input  push_ready
  );

  modport slave (
    input  push_valid, push_result, push_flags, push_opcode,
    input  rsp_valid, rsp_result, rsp_flags,
    output push_ready
  );
endinterface

// File: rtl/fp_check_fifo.sv
// fp_check_fifo -- synchronous FIFO of fp_check_entry, DEPTH entries.
//   clock, reset (sync, active-low)
//   push_i/wdata_i : write (caller guarantees not full)
//   pop_i          : read advance (caller guarantees not empty)
//   rdata_o        : head entry
//   count_o        : occupancy
// Pointers carry one extra MSB so full (DEPTH) and empty (0) are distinct.
module fp_check_fifo
  import fp_wire::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  fp_check_entry            wdata_i,
  input  logic                     pop_i,
  output fp_check_entry            rdata_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  fp_check_entry mem_q [DEPTH];
  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic [PW:0]   wr_ptr_d;
  logic [PW:0]   rd_ptr_d;

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers; reset discards any stored entries.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fp_check.sv
// fp_check -- in-order scoreboard comparing fp_unit responses to expected
// entries pushed when each operation was issued.
//   clock, reset (sync, active-low)
//   bus                 : fp_check_if.slave (push / response handshakes)
//   mismatch            : 1-cycle pulse per failed compare or orphan response
//   orphan              : sticky, response seen with no expected entry
//   halted              : checker in HALT
//   pass_cnt, fail_cnt  : saturating counters
//   last_exp, last_calc : {flags,result} of most recent mismatch
//   pending             : expected-entry FIFO occupancy
// Build option: define FP_CHECK_STOP_EN to halt on the first mismatch
// (orphans included); otherwise checking runs indefinitely.
module fp_check
  import fp_wire::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  fp_check_if.slave              bus,
  output logic                   mismatch,
  output logic                   orphan,
  output logic                   halted,
  output logic [CNT_W-1:0]       pass_cnt,
  output logic [CNT_W-1:0]       fail_cnt,
  output logic [36:0]            last_exp,
  output logic [36:0]            last_calc,
  output logic [$clog2(DEPTH):0] pending
);
  localparam int PCW = $clog2(DEPTH) + 1;

  fp_check_state_e state_q, state_d;
  fp_check_entry   head_s, push_entry_s;
  logic [PCW-1:0]  pending_s;
  logic            halted_s, push_ready_s, push_acc_s, pop_s;
  logic            orphan_ev_s, cmp_fail_s, pass_ev_s, fail_ev_s;

  logic              mismatch_q, mismatch_d;
  logic              orphan_q, orphan_d;
  logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [36:0]       last_exp_q, last_exp_d;
  logic [36:0]       last_calc_q, last_calc_d;

  assign push_entry_s = '{result: bus.push_result, flags: bus.push_flags,
                          opcode: bus.push_opcode};

  fp_check_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push_acc_s),
    .wdata_i (push_entry_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .count_o (pending_s)
  );

  // Handshake qualification and compare. Readiness is taken before any pop,
  // so a push at full is refused even when a response drains an entry.
  always_comb begin
    push_ready_s = (pending_s != PCW'(DEPTH)) && !halted_s;
    push_acc_s   = bus.push_valid && push_ready_s;
    pop_s        = bus.rsp_valid && (pending_s != '0) && !halted_s;
    orphan_ev_s  = bus.rsp_valid && (pending_s == '0) && !halted_s;
    cmp_fail_s   = !fp_entry_match(head_s, bus.rsp_result, bus.rsp_flags);
    pass_ev_s    = pop_s && !cmp_fail_s;
    fail_ev_s    = (pop_s && cmp_fail_s) || orphan_ev_s;
  end

  // Status/counter next-state. An orphan has no expected entry, so it
  // records zero as the expected value.
  always_comb begin
    mismatch_d  = fail_ev_s;
    orphan_d    = orphan_q || orphan_ev_s;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    last_exp_d  = last_exp_q;
    last_calc_d = last_calc_q;
    if (pass_ev_s && (pass_cnt_q != {CNT_W{1'b1}})) begin
      pass_cnt_d = pass_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pass_cnt_d = pass_cnt_q;
    end
    if (fail_ev_s && (fail_cnt_q != {CNT_W{1'b1}})) begin
      fail_cnt_d = fail_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      fail_cnt_d = fail_cnt_q;
    end
    if (pop_s && cmp_fail_s) begin
      last_exp_d  = {head_s.flags, head_s.result};
      last_calc_d = {bus.rsp_flags, bus.rsp_result};
    end else if (orphan_ev_s) begin
      last_exp_d  = 37'd0;
      last_calc_d = {bus.rsp_flags, bus.rsp_result};
    end else begin
      last_exp_d  = last_exp_q;
      last_calc_d = last_calc_q;
    end
  end

  // Status/counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mismatch_q  <= 1'b0;
      orphan_q    <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      last_exp_q  <= 37'd0;
      last_calc_q <= 37'd0;
    end else begin
      mismatch_q  <= mismatch_d;
      orphan_q    <= orphan_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      last_exp_q  <= last_exp_d;
      last_calc_q <= last_calc_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HALT is entered on the same edge that pulses mismatch.
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef FP_CHECK_STOP_EN
      ST_RUN: begin
        if (fail_ev_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
`else
      ST_RUN:  state_d = ST_RUN;
`endif
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted_s = 1'b0;
    case (state_q)
      ST_RUN:  halted_s = 1'b0;
      ST_HALT: halted_s = 1'b1;
      default: halted_s = 1'b0;
    endcase
  end

  assign bus.push_ready = push_ready_s;
  assign mismatch       = mismatch_q;
  assign orphan         = orphan_q;
  assign halted         = halted_s;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign last_exp       = last_exp_q;
  assign last_calc      = last_calc_q;
  assign pending        = pending_s;

endmodule

// File: tb/tb_fp_check.sv
// tb_fp_check -- self-checking bench for fp_check: directed scenarios plus
// randomized traffic, all checked cycle by cycle against a queue-based model.
module tb_fp_check;
  import fp_wire::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             mismatch, orphan, halted;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [36:0]      last_exp, last_calc;
  logic [3:0]       pending;

  fp_check_if bus ();

  fp_check #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .mismatch  (mismatch),
    .orphan    (orphan),
    .halted    (halted),
    .pass_cnt  (pass_cnt),
    .fail_cnt  (fail_cnt),
    .last_exp  (last_exp),
    .last_calc (last_calc),
    .pending   (pending)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  fp_check_entry q[$];
  int            m_pass, m_fail;
  bit            m_mis, m_orphan, m_halt;
  logic [36:0]   m_last_exp, m_last_calc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Spec rule: canonical NaN response to a non-f2i op only needs exponent+quiet bit.
  function automatic bit ref_ok(input fp_check_entry e, input logic [31:0] r,
                                input logic [4:0] f);
    logic [31:0] nan;
    logic [31:0] mask;
    nan  = 32'h7FC0_0000;
    mask = 32'h7FC0_0000;   // bits 30..22
    if (f != e.flags) return 1'b0;
    if (e.opcode[9] == 1'b0 && r == nan) return (r & mask) == (e.result & mask);
    return r == e.result;
  endfunction

  task automatic model_fail();
    if (m_fail < CMAX) m_fail++;
    m_mis = 1'b1;
`ifdef FP_CHECK_STOP_EN
    m_halt = 1'b1;
`endif
  endtask

  task automatic model_step();
    fp_check_entry e;
    bit rdy;
    m_mis = 1'b0;
    if (!reset) begin
      q.delete();
      m_pass = 0; m_fail = 0; m_orphan = 1'b0; m_halt = 1'b0;
      m_last_exp = '0; m_last_calc = '0;
    end else if (!m_halt) begin
      rdy = (q.size() != DEPTH);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          m_orphan = 1'b1;
          m_last_exp = '0;
          m_last_calc = {bus.rsp_flags, bus.rsp_result};
          model_fail();
        end else begin
          e = q.pop_front();
          if (ref_ok(e, bus.rsp_result, bus.rsp_flags)) begin
            if (m_pass < CMAX) m_pass++;
          end else begin
            m_last_exp = {e.flags, e.result};
            m_last_calc = {bus.rsp_flags, bus.rsp_result};
            model_fail();
          end
        end
      end
      if (bus.push_valid && rdy)
        q.push_back('{result: bus.push_result, flags: bus.push_flags, opcode: bus.push_opcode});
    end
  endtask

  task automatic check_all();
    chk("pending",    64'(pending),        64'(q.size()));
    chk("push_ready", 64'(bus.push_ready), 64'((q.size() != DEPTH) && !m_halt));
    chk("mismatch",   64'(mismatch),       64'(m_mis));
    chk("orphan",     64'(orphan),         64'(m_orphan));
    chk("halted",     64'(halted),         64'(m_halt));
    chk("pass_cnt",   64'(pass_cnt),       64'(m_pass));
    chk("fail_cnt",   64'(fail_cnt),       64'(m_fail));
    chk("last_exp",   64'(last_exp),       64'(m_last_exp));
    chk("last_calc",  64'(last_calc),      64'(m_last_calc));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit pv, input logic [31:0] pr, input logic [4:0] pf,
                        input logic [9:0] po, input bit rv, input logic [31:0] rr,
                        input logic [4:0] rf);
    bus.push_valid = pv; bus.push_result = pr; bus.push_flags = pf; bus.push_opcode = po;
    bus.rsp_valid = rv; bus.rsp_result = rr; bus.rsp_flags = rf;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b0, 32'h0, 5'h0);
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b0, 32'h0, 5'h0);
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pick_result();
    case ($urandom_range(0, 4))
      0: return 32'h3F80_0000;
      1: return 32'h7FC0_0000;
      2: return 32'hFFC0_0001;
      3: return 32'h7F80_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    fp_check_entry h;
    logic [31:0] rr;
    logic [4:0]  rf;
    bit          rv;
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b0, 32'h0, 5'h0);
    do_reset();
    chk("reset_pass", 64'(pass_cnt), 64'd0);
    chk("reset_ready", 64'(bus.push_ready), 64'd1);

    // simple pass after a 5-cycle latency
    set_in(1'b1, 32'h3F80_0000, 5'h00, 10'h001, 1'b0, 32'h0, 5'h0); cyc();
    idle(4);
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h3F80_0000, 5'h00); cyc();
    idle(1);
    chk("simple_pass", 64'(pass_cnt), 64'd1);
    chk("simple_nomis", 64'(mismatch), 64'd0);

    // canonical NaN relaxation
    do_reset();
    set_in(1'b1, 32'h7FC0_0000, 5'h00, 10'h002, 1'b0, 32'h0, 5'h0); cyc();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h7FC0_0000, 5'h00); cyc();
    set_in(1'b1, 32'hFFC0_0001, 5'h00, 10'h002, 1'b0, 32'h0, 5'h0); cyc();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h7FC0_0000, 5'h00); cyc();
    idle(1);
    chk("nan_pass", 64'(pass_cnt), 64'd2);
    chk("nan_fail", 64'(fail_cnt), 64'd0);

    // f2i op gets no NaN relaxation
    do_reset();
    set_in(1'b1, 32'hFFC0_0001, 5'h00, 10'h200, 1'b0, 32'h0, 5'h0); cyc();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h7FC0_0000, 5'h00); cyc();
    chk("f2i_fail", 64'(fail_cnt), 64'd1);

    // flag mismatch
    do_reset();
    set_in(1'b1, 32'h4000_0000, 5'h01, 10'h001, 1'b0, 32'h0, 5'h0); cyc();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h4000_0000, 5'h00); cyc();
    chk("flag_mis", 64'(mismatch), 64'd1);
    chk("flag_failcnt", 64'(fail_cnt), 64'd1);
    chk("flag_lastexp", 64'(last_exp), 64'h01_4000_0000);
    chk("flag_lastcalc", 64'(last_calc), 64'h00_4000_0000);
    idle(1);
    chk("flag_pulse_end", 64'(mismatch), 64'd0);

    // full FIFO
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, 32'(i), 5'h00, 10'h001, 1'b0, 32'h0, 5'h0); cyc();
    end
    chk("full_ready", 64'(bus.push_ready), 64'd0);
    set_in(1'b1, 32'h99, 5'h00, 10'h001, 1'b0, 32'h0, 5'h0); cyc();
    chk("full_drop", 64'(pending), 64'd8);
    set_in(1'b1, 32'h98, 5'h00, 10'h001, 1'b1, 32'h0, 5'h00); cyc();
    chk("full_pushpop", 64'(pending), 64'd7);
    chk("full_pass", 64'(pass_cnt), 64'd1);

    // orphan
    do_reset();
    set_in(1'b1, 32'h1, 5'h00, 10'h001, 1'b1, 32'h1234, 5'h00); cyc();
    chk("orphan_flag", 64'(orphan), 64'd1);
    chk("orphan_fail", 64'(fail_cnt), 64'd1);
    chk("orphan_nobypass", 64'(pending), 64'd1);
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h5678, 5'h00); cyc();
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b1, 32'h5678, 5'h00); cyc();
`ifdef FP_CHECK_STOP_EN
    chk("orphan_halt", 64'(halted), 64'd1);
    chk("orphan_frozen", 64'(fail_cnt), 64'd1);
`else
    chk("orphan_run", 64'(halted), 64'd0);
    chk("orphan_count", 64'(fail_cnt), 64'd3);
`endif

    // reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 32'(i), 5'h00, 10'h001, 1'b0, 32'h0, 5'h0); cyc();
    end
    chk("mid_pending5", 64'(pending), 64'd5);
    set_in(1'b0, 32'h0, 5'h0, 10'h0, 1'b0, 32'h0, 5'h0);
    reset = 1'b0; cyc(); reset = 1'b1;
    chk("mid_pending0", 64'(pending), 64'd0);
    chk("mid_ready", 64'(bus.push_ready), 64'd1);
    chk("mid_cnt", 64'(pass_cnt) + 64'(fail_cnt), 64'd0);

    // randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 120; c++) begin
        rr = $urandom; rf = 5'($urandom);
        rv = 1'b0;
        if (q.size() != 0) begin
          rv = ($urandom_range(0, 99) < 45);
          h = q[0];
          rr = h.result; rf = h.flags;
          if (h.result[30:22] == 9'h1FF && $urandom_range(0, 1) == 1) rr = 32'h7FC0_0000;
          if ($urandom_range(0, 19) == 0) rf = rf ^ 5'h01;
        end else begin
          rv = ($urandom_range(0, 99) < 3);
        end
        set_in($urandom_range(0, 1) == 1, pick_result(), 5'($urandom),
               10'(1) << $urandom_range(0, 9), rv, rr, rf);
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fp_check.md
FP_CHECK -- requirements
Module: fp_check

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning expected-entry FIFO depth (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of pass/fail counters.
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port push_valid  input  1  expected entry offered, issued in the same cycle the operation enters fp_unit.
REQ-006 SHALL have port push_result  input  32  expected result.
REQ-007 SHALL have port push_flags  input  5  expected fflags.
REQ-008 SHALL have port push_opcode  input  10  one-hot opcode; bit 9 = fcvt_f2i.
REQ-009 SHALL have port push_ready  output  1  entry can be accepted.
REQ-010 SHALL have port rsp_valid  input  1  fp_unit ready strobe.
REQ-011 SHALL have port rsp_result  input  32  fp_unit result.
REQ-012 SHALL have port rsp_flags  input  5  fp_unit flags.
REQ-013 SHALL have port mismatch  output  1  one-cycle pulse per failed compare or orphan response.
REQ-014 SHALL have port orphan  output  1  sticky: response arrived with FIFO empty.
REQ-015 SHALL have port halted  output  1  checker in HALT state.
REQ-016 SHALL have ports pass_cnt, fail_cnt  output  CNT_W  saturating counters.
REQ-017 SHALL have ports last_exp, last_calc  output  37  {flags,result} of most recent mismatch.
REQ-018 SHALL have port pending  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 SHALL accept an entry when push_valid && push_ready; push_ready = (pending != DEPTH) && !halted.
REQ-020 SHALL pop the head entry on every rsp_valid when pending != 0 and not halted; responses match entries strictly in order.
REQ-021 SHALL, on simultaneous push and pop, keep pending unchanged; push at full is not accepted even if a pop occurs that cycle.
REQ-022 SHALL treat rsp_valid while pending == 0 as orphan: orphan set, fail_cnt incremented, mismatch pulsed; a push in that same cycle is not bypassed.
REQ-023 SHALL compare result: if head opcode[9]==0 and rsp_result==32'h7FC00000, only bits [30:22] are compared; otherwise all 32 bits.
REQ-024 SHALL compare flags on all 5 bits; fail if either result or flags differs.
REQ-025 SHALL register compare outcome: mismatch, counters and last_exp/last_calc update on the clock edge after rsp_valid (1-cycle latency).
REQ-026 SHALL saturate pass_cnt and fail_cnt at all-ones.
REQ-027 SHALL implement FSM states RUN and HALT; RUN->HALT per REQ-031; HALT exits only on reset.
REQ-028 SHALL ignore rsp_valid and push_valid while halted; counters and pending frozen.

Reset
REQ-029 SHALL, when reset low at clock edge, clear FIFO pointers, pending=0, pass_cnt=0, fail_cnt=0, mismatch=0, orphan=0, last_exp=0, last_calc=0, state=RUN.
REQ-030 SHALL discard in-flight expected entries on reset mid-operation; push_ready=1 in the first cycle after reset.

Configuration
REQ-031 SHALL honour macro FP_CHECK_STOP_EN: defined -> first mismatch (incl. orphan) moves FSM to HALT in the same edge that pulses mismatch; undefined -> FSM never leaves RUN, halted tied 0, checking continues.

Structure
REQ-032 SHALL declare typedef fp_check_entry (result, flags, opcode) and the canonical-NaN constant 32'h7FC00000 in package fp_wire.
REQ-033 SHALL instantiate one sub-module fp_check_fifo (synchronous FIFO of fp_check_entry, DEPTH entries, wrap-around pointers with extra MSB).

Verification
REQ-034 SHALL cover: push {3F800000,00000}, rsp {3F800000,00000} 5 cycles later -> pass_cnt=1, mismatch=0.
REQ-035 SHALL cover: expected 7FC00000 opcode=0000000010, rsp 7FC00000 flags match; then expected FFC00001 same opcode, rsp 7FC00000 -> both pass (bits 30:22 equal).
REQ-036 SHALL cover: push result 40000000 flags 00001, rsp 40000000 flags 00000 -> mismatch pulse next cycle, fail_cnt=1, last_exp={00001,40000000}, last_calc={00000,40000000}.
REQ-037 SHALL cover: 8 pushes, no rsp -> push_ready=0, 9th push dropped, pending=8; push+rsp same cycle at pending=8 -> pending=7, push rejected.
REQ-038 SHALL cover: rsp_valid with pending=0 -> orphan=1, fail_cnt=1; with FP_CHECK_STOP_EN halted=1 and subsequent rsp ignored, without it counting continues.
REQ-039 SHALL cover: reset asserted with pending=5 -> next cycle pending=0, counters 0, push_ready=1.
